interrupt_ack_sequencer: RTL and testbench

Control-side counterpart of the in-service register in the 8259A-compatible interrupt controller. It decodes the CPU's two-pulse 8086 INTA sequence and issues the one-cycle `acknowledge` that sets the ISR bit. It drives the interrupt vector onto the data bus, decodes OCW2 writes, and generates the `end_of_interrupt` clear masks consumed by the ISR, covering both automatic EOI and commanded EOI.

---
 rtl/pic_pkg.sv | 30 +++
 rtl/eoi_decoder.sv | 40 ++++
 rtl/interrupt_ack_sequencer.sv | 86 ++++++++
 tb/tb_interrupt_ack_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-compatible interrupt controller slice:
// OCW2 command codes, INTA sequencing states and small bit-vector helpers.
package pic_pkg;

  localparam logic [2:0] OCW2_NS_EOI = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    PULSE1,
    GAP,
    PULSE2
  } inta_state_t;

  // Binary index of a one-hot vector; returns 0 for an all-zero input.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Isolates the lowest-index set bit (bit 0 is highest priority).
  function automatic logic [7:0] lowest_set_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/eoi_decoder.sv
// Registered OCW2 EOI decode merged with the automatic-EOI request into
// a single one-cycle ISR clear mask.
module eoi_decoder
  import pic_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic [7:0] in_service_register,
  input  logic       aeoi_fire,
  input  logic [2:0] aeoi_level,
  output logic [7:0] end_of_interrupt
);

  logic [7:0] ocw_mask;
  logic [7:0] aeoi_mask;

  always_comb begin
    ocw_mask = '0;
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        OCW2_NS_EOI: ocw_mask = lowest_set_bit(in_service_register);
        OCW2_SP_EOI: ocw_mask = 8'h01 << ocw2_data[2:0];
        default:     ocw_mask = '0;
      endcase
    end
  end

  always_comb begin
    aeoi_mask = '0;
    if (aeoi_fire) aeoi_mask = 8'h01 << aeoi_level;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) end_of_interrupt <= '0;
    else          end_of_interrupt <= ocw_mask | aeoi_mask;
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086 two-pulse INTA sequencer: acknowledge to the ISR, vector drive on
// the second pulse, and automatic / commanded EOI mask generation.
module interrupt_ack_sequencer
  import pic_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       inta_n,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  input  logic [7:0] highest_priority_interrupt,
  input  logic [7:0] in_service_register,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic       acknowledge,
  output logic [7:0] end_of_interrupt,
  output logic [7:0] data_out,
  output logic       data_out_enable,
  output logic       ack_busy
);

  inta_state_t state, state_next;
  logic        inta_prev;
  logic        inta_fall, inta_rise;
  logic [2:0]  level;
  logic        spurious;
  logic        entry;
  logic        no_request;
  logic        aeoi_fire;

  always_comb begin
    inta_fall  = inta_prev & ~inta_n;
    inta_rise  = ~inta_prev & inta_n;
    no_request = (highest_priority_interrupt == '0);
    entry      = (state == IDLE) && inta_fall;
    aeoi_fire  = (state == PULSE2) && inta_rise && auto_eoi && !spurious;
    ack_busy   = (state != IDLE);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inta_fall) state_next = PULSE1;
      PULSE1:  if (inta_rise) state_next = GAP;
      GAP:     if (inta_fall) state_next = PULSE2;
      PULSE2:  if (inta_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector and enable are registered from the next state so they appear
  // the cycle after the second low is sampled and drop on PULSE2 exit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      inta_prev       <= 1'b1;
      level           <= '0;
      spurious        <= 1'b0;
      acknowledge     <= 1'b0;
      data_out        <= '0;
      data_out_enable <= 1'b0;
    end else begin
      state     <= state_next;
      inta_prev <= inta_n;
      if (entry) begin
        level    <= no_request ? 3'd7 : onehot_to_index(highest_priority_interrupt);
        spurious <= no_request;
      end
      acknowledge     <= entry && !no_request;
      data_out_enable <= (state_next == PULSE2);
      data_out        <= (state_next == PULSE2) ? {vector_base, level} : '0;
    end
  end

  eoi_decoder u_eoi_decoder (
    .clock               (clock),
    .reset_n             (reset_n),
    .ocw2_write          (ocw2_write),
    .ocw2_data           (ocw2_data),
    .in_service_register (in_service_register),
    .aeoi_fire           (aeoi_fire),
    .aeoi_level          (level),
    .end_of_interrupt    (end_of_interrupt)
  );

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench: stimulus schedules expected events by cycle number,
// a negedge monitor compares every output against them each cycle.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       inta_n = 1'b1;
  logic       auto_eoi = 1'b0;
  logic [4:0] vector_base = '0;
  logic [7:0] highest_priority_interrupt = '0;
  logic [7:0] in_service_register = '0;
  logic       ocw2_write = 1'b0;
  logic [7:0] ocw2_data = '0;
  logic       acknowledge;
  logic [7:0] end_of_interrupt;
  logic [7:0] data_out;
  logic       data_out_enable;
  logic       ack_busy;

  interrupt_ack_sequencer dut (
    .clock                      (clk),
    .reset_n                    (reset_n),
    .inta_n                     (inta_n),
    .auto_eoi                   (auto_eoi),
    .vector_base                (vector_base),
    .highest_priority_interrupt (highest_priority_interrupt),
    .in_service_register        (in_service_register),
    .ocw2_write                 (ocw2_write),
    .ocw2_data                  (ocw2_data),
    .acknowledge                (acknowledge),
    .end_of_interrupt           (end_of_interrupt),
    .data_out                   (data_out),
    .data_out_enable            (data_out_enable),
    .ack_busy                   (ack_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] v;
  } ev_t;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         quiet_cyc = 1;
  int         ack_q[$];
  int         busy_q[$];
  ev_t        vec_q[$];
  logic [7:0] eoi_exp[int];

  bit         rand_ocw = 1'b0;
  bit         pend_valid = 1'b0;
  logic [7:0] pend_d, pend_isr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ocw_model(input logic [7:0] d, input logic [7:0] isr);
    logic [7:0] m;
    m = 8'h00;
    if (d[7:5] == 3'b001) begin
      for (int i = 7; i >= 0; i--) if (isr[i]) m = 8'h01 << i;
    end else if (d[7:5] == 3'b011) begin
      m = 8'h01 << d[2:0];
    end
    return m;
  endfunction

  function automatic logic [2:0] level_model(input logic [7:0] hpi);
    logic [2:0] l;
    l = 3'd7;
    for (int i = 0; i < 8; i++) if (hpi[i]) l = 3'(i);
    return l;
  endfunction

  task automatic add_eoi(input int c, input logic [7:0] m);
    if (m != 8'h00) eoi_exp[c] = (eoi_exp.exists(c) ? eoi_exp[c] : 8'h00) | m;
  endtask

  task automatic drive_ocw(input logic [7:0] d, input logic [7:0] isr);
    ocw2_write          = 1'b1;
    ocw2_data           = d;
    in_service_register = isr;
    add_eoi(cyc + 1, ocw_model(d, isr));
  endtask

  task automatic advance();
    logic [7:0] d;
    if (pend_valid) begin
      drive_ocw(pend_d, pend_isr);
      pend_valid = 1'b0;
    end else if (rand_ocw && $urandom_range(0, 2) == 0) begin
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       d[7:5] = 3'b001;
        1:       d[7:5] = 3'b011;
        default: d[7:5] = 3'b010;
      endcase
      drive_ocw(d, 8'($urandom));
    end
    @(posedge clk);
    #1;
    ocw2_write = 1'b0;
  endtask

  task automatic ocw_cmd(input logic [7:0] d, input logic [7:0] isr);
    pend_d = d; pend_isr = isr; pend_valid = 1'b1;
    advance();
  endtask

  task automatic inta_seq(input logic [7:0] hpi, input logic [4:0] vb, input bit aeoi,
                          input int l1, input int g, input int l2,
                          input bit cvalid, input logic [7:0] cdata);
    int n, m, k;
    bit spur;
    logic [2:0] lvl;
    n = cyc; m = n + l1 + g; k = m + l2;
    spur = (hpi == 8'h00);
    lvl  = level_model(hpi);
    inta_n = 1'b0; highest_priority_interrupt = hpi; vector_base = vb; auto_eoi = aeoi;
    if (!spur) ack_q.push_back(n + 1);
    for (int c = n + 1; c <= k; c++) busy_q.push_back(c);
    for (int c = m + 1; c <= k; c++) vec_q.push_back('{c: c, v: {vb, lvl}});
    if (aeoi && !spur) add_eoi(k + 1, 8'h01 << lvl);
    advance();
    highest_priority_interrupt = 8'($urandom);
    repeat (l1 - 1) advance();
    inta_n = 1'b1;
    repeat (g) advance();
    inta_n = 1'b0;
    repeat (l2) advance();
    inta_n = 1'b1;
    if (cvalid) begin pend_d = cdata; pend_isr = 8'($urandom); pend_valid = 1'b1; end
    advance();
  endtask

  task automatic reset_in_gap(input logic [7:0] hpi, input logic [4:0] vb, input int l1);
    int n, r;
    bit saved;
    saved = rand_ocw;
    rand_ocw = 1'b0;
    n = cyc; r = n + l1 + 1;
    inta_n = 1'b0; highest_priority_interrupt = hpi; vector_base = vb; auto_eoi = 1'b1;
    if (hpi != 8'h00) ack_q.push_back(n + 1);
    for (int c = n + 1; c <= r; c++) busy_q.push_back(c);
    advance();
    highest_priority_interrupt = 8'($urandom);
    repeat (l1 - 1) advance();
    inta_n = 1'b1;
    advance();
    reset_n = 1'b0;
    quiet_cyc = r + 1;
    advance();
    reset_n = 1'b1;
    advance();
    rand_ocw = saved;
  endtask

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit         e_ack, e_busy, e_de;
    logic [7:0] e_vec, e_eoi;
    while (ack_q.size() > 0 && ack_q[0] < cyc) void'(ack_q.pop_front());
    while (busy_q.size() > 0 && busy_q[0] < cyc) void'(busy_q.pop_front());
    while (vec_q.size() > 0 && vec_q[0].c < cyc) void'(vec_q.pop_front());
    e_ack  = (ack_q.size() > 0 && ack_q[0] == cyc);
    e_busy = (busy_q.size() > 0 && busy_q[0] == cyc);
    e_de   = (vec_q.size() > 0 && vec_q[0].c == cyc);
    e_vec  = e_de ? vec_q[0].v : 8'h00;
    e_eoi  = eoi_exp.exists(cyc) ? eoi_exp[cyc] : 8'h00;
    if (e_ack) void'(ack_q.pop_front());
    if (e_busy) void'(busy_q.pop_front());
    if (e_de) void'(vec_q.pop_front());
    if (eoi_exp.exists(cyc)) eoi_exp.delete(cyc);

    chk(acknowledge === e_ack, "acknowledge", int'(acknowledge), int'(e_ack));
    chk(ack_busy === e_busy, "ack_busy", int'(ack_busy), int'(e_busy));
    chk(data_out_enable === e_de, "data_out_enable", int'(data_out_enable), int'(e_de));
    chk(data_out === e_vec, "data_out", int'(data_out), int'(e_vec));
    chk(end_of_interrupt === e_eoi, "end_of_interrupt", int'(end_of_interrupt), int'(e_eoi));
    if (cyc == quiet_cyc)
      chk({acknowledge, end_of_interrupt, data_out, data_out_enable, ack_busy} === 19'd0,
          "quiet_after_reset",
          int'({acknowledge, end_of_interrupt, data_out, data_out_enable, ack_busy}), 0);
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    advance();

    inta_seq(8'h08, 5'b01000, 1'b0, 1, 1, 1, 1'b0, 8'h00);
    advance();
    inta_seq(8'h08, 5'b01000, 1'b1, 2, 1, 2, 1'b0, 8'h00);
    advance();
    inta_seq(8'h00, 5'b01000, 1'b1, 1, 2, 1, 1'b0, 8'h00);
    advance();
    ocw_cmd(8'h20, 8'h24);
    ocw_cmd(8'h65, 8'h24);
    ocw_cmd(8'h20, 8'h00);
    ocw_cmd(8'h45, 8'hff);
    advance();
    inta_seq(8'h02, 5'b10101, 1'b1, 1, 1, 1, 1'b1, 8'h66);
    advance();
    reset_in_gap(8'h10, 5'b00110, 2);
    inta_seq(8'h80, 5'b00110, 1'b1, 1, 1, 1, 1'b0, 8'h00);

    rand_ocw = 1'b1;
    for (int it = 0; it < 60; it++) begin
      logic [7:0] hpi;
      hpi = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        reset_in_gap(hpi, 5'($urandom), $urandom_range(1, 3));
      else
        inta_seq(hpi, 5'($urandom), 1'($urandom), $urandom_range(1, 3),
                 $urandom_range(1, 3), $urandom_range(1, 3), 1'b0, 8'h00);
      repeat ($urandom_range(0, 2)) advance();
    end
    rand_ocw = 1'b0;
    repeat (4) advance();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
